// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scanout reads have priority, and a waiting CPU
// request is guaranteed a slot after MAX_VGA_RUN consecutive VGA grants.
module vram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 8,
  parameter int MAX_VGA_RUN = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_ack,
  output logic              vga_rvalid,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_VGA_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_VGA_RUN);

  typedef enum logic [1:0] {
    IDLE,
    GNT_VGA,
    GNT_CPU
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] run_cnt;
  logic             cap_cpu;
  logic             cap_vga;
  logic             grant_vga;
  logic             grant_cpu;

  // VGA wins unless the CPU has already been passed over MAX_VGA_RUN times.
  assign grant_vga = vga_req && !(cpu_req && (run_cnt == RUN_MAX));
  assign grant_cpu = !grant_vga && cpu_req;

  // NOTE: every register below uses non-blocking assignment so all state and
  // outputs update together on the edge, independent of statement order.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      run_cnt    <= '0;
      cap_cpu    <= 1'b0;
      cap_vga    <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      vga_ack    <= 1'b0;
      vga_rvalid <= 1'b0;
      vga_rdata  <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      cpu_ack    <= 1'b0;
      vga_ack    <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rvalid <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      cap_cpu    <= 1'b0;
      cap_vga    <= 1'b0;

      // Read data from the previous grant is on ram_rdata this cycle.
      if (cap_cpu) begin
        cpu_rdata  <= ram_rdata;
        cpu_rvalid <= 1'b1;
      end
      if (cap_vga) begin
        vga_rdata  <= ram_rdata;
        vga_rvalid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_vga) begin
            state    <= GNT_VGA;
            vga_ack  <= 1'b1;
            ram_en   <= 1'b1;
            ram_addr <= vga_addr;
          end else if (grant_cpu) begin
            state     <= GNT_CPU;
            cpu_ack   <= 1'b1;
            ram_en    <= 1'b1;
            ram_we    <= cpu_we;
            ram_addr  <= cpu_addr;
            ram_wdata <= cpu_wdata;
          end
        end
        GNT_VGA: begin
          state   <= IDLE;
          cap_vga <= 1'b1;
        end
        GNT_CPU: begin
          state   <= IDLE;
          cap_cpu <= !ram_we;
        end
        default: state <= IDLE;
      endcase

      if (!cpu_req) begin
        run_cnt <= '0;
      end else if (state == IDLE && grant_cpu) begin
        run_cnt <= '0;
      end else if (state == IDLE && grant_vga && run_cnt != RUN_MAX) begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed and random checks of vram_arbiter against a behavioural 1-cycle RAM.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_vram_arbiter;

  localparam int ADDR_W      = 11;
  localparam int DATA_W      = 8;
  localparam int MAX_VGA_RUN = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_ack, vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic              mem_load;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_VGA_RUN(MAX_VGA_RUN)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_ack(vga_ack), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    if (a == 11'h123) return 8'hC3;
    return a[7:0] ^ 8'hA5;
  endfunction

  // RAM macro model: synchronous write, registered read data.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= init_val(ADDR_W'(i));
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({cpu_ack, cpu_rvalid, cpu_rdata, vga_ack, vga_rvalid, vga_rdata,
         ram_en, ram_we, ram_addr, ram_wdata} !== 41'd0)
      $display("FAIL reset_outputs: got en=%b ack=%b/%b addr=%h want all zero",
               ram_en, cpu_ack, vga_ack, ram_addr);
    else pass_cnt++;
  endtask

  task automatic test_cpu_write_read();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h010; cpu_wdata = 8'h5A;
    tick();
    total_cnt++;
    if ({cpu_ack, vga_ack, ram_en, ram_we, ram_addr, ram_wdata} !== {4'b1011, 11'h010, 8'h5A})
      $display("FAIL cpu_write_ack: ack=%b en=%b we=%b addr=%h wdata=%h want ack=1 en=1 we=1 addr=010 wdata=5a",
               cpu_ack, ram_en, ram_we, ram_addr, ram_wdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({cpu_ack, ram_en, ram_we} !== 3'b000)
      $display("FAIL cpu_write_release: ack/en/we=%b want 000", {cpu_ack, ram_en, ram_we});
    else pass_cnt++;
    cpu_we = 1'b0;
    tick();
    total_cnt++;
    if ({cpu_ack, ram_en, ram_we, cpu_rvalid, ram_addr} !== {4'b1100, 11'h010})
      $display("FAIL cpu_read_ack: ack/en/we/rvalid=%b addr=%h want 1100 addr=010",
               {cpu_ack, ram_en, ram_we, cpu_rvalid}, ram_addr);
    else pass_cnt++;
    tick();
    cpu_req = 1'b0;
    total_cnt++;
    if ({cpu_ack, cpu_rvalid} !== 2'b00)
      $display("FAIL cpu_read_early: ack/rvalid=%b want 00", {cpu_ack, cpu_rvalid});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h5A)
      $display("FAIL cpu_read_data: rvalid=%b rdata=%h want rvalid=1 rdata=5a", cpu_rvalid, cpu_rdata);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 8'h5A)
      $display("FAIL cpu_rdata_hold: rvalid=%b rdata=%h want rvalid=0 rdata=5a", cpu_rvalid, cpu_rdata);
    else pass_cnt++;
  endtask

  task automatic test_vga_read();
    vga_req = 1'b1; vga_addr = 11'h123;
    tick();
    total_cnt++;
    if ({vga_ack, cpu_ack, ram_en, ram_we, ram_addr} !== {4'b1010, 11'h123})
      $display("FAIL vga_read_ack: vack/cack/en/we=%b addr=%h want 1010 addr=123",
               {vga_ack, cpu_ack, ram_en, ram_we}, ram_addr);
    else pass_cnt++;
    tick();
    vga_req = 1'b0;
    total_cnt++;
    if ({vga_ack, vga_rvalid, ram_en} !== 3'b000)
      $display("FAIL vga_read_release: ack/rvalid/en=%b want 000", {vga_ack, vga_rvalid, ram_en});
    else pass_cnt++;
    tick();
    total_cnt++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== 8'hC3)
      $display("FAIL vga_read_data: rvalid=%b rdata=%h want rvalid=1 rdata=c3", vga_rvalid, vga_rdata);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int idx = 0, rv_idx = 0, acks = 0, last_ack = -1;
    bit change = 1'b0, cpu_seen = 1'b0;
    vga_req = 1'b1; vga_addr = '0;
    for (int cyc = 0; cyc < 40 && rv_idx < 8; cyc++) begin
      tick();
      if (cpu_ack) cpu_seen = 1'b1;
      if (vga_rvalid) begin
        total_cnt++;
        if (vga_rdata !== init_val(ADDR_W'(rv_idx)))
          $display("FAIL b2b_data[%0d]: got %h want %h", rv_idx, vga_rdata, init_val(ADDR_W'(rv_idx)));
        else pass_cnt++;
        rv_idx++;
      end
      if (vga_ack) begin
        total_cnt++;
        if (ram_addr !== ADDR_W'(idx) || (last_ack >= 0 && cyc - last_ack != 2))
          $display("FAIL b2b_ack[%0d]: addr=%h gap=%0d want addr=%h gap=2",
                   idx, ram_addr, cyc - last_ack, idx);
        else pass_cnt++;
        last_ack = cyc;
        acks++;
        change = 1'b1;
      end else if (change) begin
        change = 1'b0;
        idx++;
        if (idx == 8) vga_req = 1'b0;
        else          vga_addr = ADDR_W'(idx);
      end
    end
    vga_req = 1'b0;
    total_cnt++;
    if (rv_idx != 8 || acks != 8 || cpu_seen)
      $display("FAIL b2b_totals: rvalids=%0d acks=%0d cpu_ack_seen=%b want 8 8 0", rv_idx, acks, cpu_seen);
    else pass_cnt++;
  endtask

  task automatic test_starvation();
    int n = 0;
    bit [9:0] exp_cpu = 10'h210;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200;
    vga_req = 1'b1; vga_addr = 11'h100;
    for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
      tick();
      if (vga_ack || cpu_ack) begin
        total_cnt++;
        if (cpu_ack === vga_ack || cpu_ack !== exp_cpu[n])
          $display("FAIL starve_grant[%0d]: cpu_ack=%b vga_ack=%b want cpu_ack=%b", n, cpu_ack, vga_ack, exp_cpu[n]);
        else pass_cnt++;
        if (cpu_ack) begin
          total_cnt++;
          if (dut.run_cnt !== '0)
            $display("FAIL starve_run_cnt[%0d]: got %0d want 0", n, dut.run_cnt);
          else pass_cnt++;
        end
        n++;
      end
    end
    cpu_req = 1'b0; vga_req = 1'b0;
    total_cnt++;
    if (n != 10) $display("FAIL starve_timeout: grants=%0d want 10", n);
    else pass_cnt++;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_access();
    bit seen = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h055;
    tick();
    total_cnt++;
    if (cpu_ack !== 1'b1) $display("FAIL rst_mid_grant: cpu_ack=%b want 1", cpu_ack);
    else pass_cnt++;
    reset = 1'b1; cpu_req = 1'b0;
    tick();
    test_reset();
    reset = 1'b0;
    repeat (3) begin
      tick();
      if (cpu_ack || cpu_rvalid) seen = 1'b1;
    end
    total_cnt++;
    if (seen) $display("FAIL rst_mid_suppress: cpu ack/rvalid after reset got 1 want 0");
    else pass_cnt++;
    vga_req = 1'b1; vga_addr = 11'h123;
    tick();
    total_cnt++;
    if (vga_ack !== 1'b1 || ram_addr !== 11'h123)
      $display("FAIL rst_mid_vga_ack: ack=%b addr=%h want 1 123", vga_ack, ram_addr);
    else pass_cnt++;
    tick();
    vga_req = 1'b0;
    tick();
    total_cnt++;
    if (vga_rvalid !== 1'b1 || vga_rdata !== 8'hC3 || cpu_rvalid !== 1'b0)
      $display("FAIL rst_mid_vga_data: rvalid=%b rdata=%h cpu_rvalid=%b want 1 c3 0",
               vga_rvalid, vga_rdata, cpu_rvalid);
    else pass_cnt++;
  endtask

  task automatic test_random();
    bit cpu_pend = 0, cpu_drop = 0, vga_pend = 0, vga_drop = 0, exp_rv;
    int cpu_wait = 0, cpu_cd = 0, vga_cd = 0;
    int cpu_reqs = 0, cpu_acks = 0, vga_reqs = 0, vga_acks = 0;
    logic [DATA_W-1:0] cpu_exp = '0, vga_exp = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick();
      exp_rv = (cpu_cd == 1);
      if (cpu_cd > 0) cpu_cd--;
      if (exp_rv || cpu_rvalid) begin
        total_cnt++;
        if (cpu_rvalid !== exp_rv || cpu_rdata !== cpu_exp)
          $display("FAIL rand_cpu_rdata@%0d: rvalid=%b rdata=%h want %b %h", cyc, cpu_rvalid, cpu_rdata, exp_rv, cpu_exp);
        else pass_cnt++;
      end
      exp_rv = (vga_cd == 1);
      if (vga_cd > 0) vga_cd--;
      if (exp_rv || vga_rvalid) begin
        total_cnt++;
        if (vga_rvalid !== exp_rv || vga_rdata !== vga_exp)
          $display("FAIL rand_vga_rdata@%0d: rvalid=%b rdata=%h want %b %h", cyc, vga_rvalid, vga_rdata, exp_rv, vga_exp);
        else pass_cnt++;
      end
      if (cpu_pend) cpu_wait++;
      if (cpu_ack) begin
        total_cnt++;
        if (!cpu_pend || cpu_wait > 2 * (MAX_VGA_RUN + 1))
          $display("FAIL rand_cpu_ack@%0d: pending=%b wait=%0d want pending=1 wait<=%0d",
                   cyc, cpu_pend, cpu_wait, 2 * (MAX_VGA_RUN + 1));
        else pass_cnt++;
        cpu_acks++;
        if (!cpu_we) begin cpu_exp = mem[cpu_addr]; cpu_cd = 2; end
      end
      if (vga_ack) begin
        total_cnt++;
        if (!vga_pend) $display("FAIL rand_vga_ack@%0d: pending=0 want 1", cyc);
        else pass_cnt++;
        vga_acks++;
        vga_exp = mem[vga_addr];
        vga_cd  = 2;
      end
      // Requesters: drop in the cycle after ack, then maybe issue a new request.
      if (cpu_drop) begin cpu_drop = 1'b0; cpu_req = 1'b0; end
      if (cpu_ack) begin cpu_pend = 1'b0; cpu_drop = 1'b1; end
      if (vga_drop) begin vga_drop = 1'b0; vga_req = 1'b0; end
      if (vga_ack) begin vga_pend = 1'b0; vga_drop = 1'b1; end
      if (cyc < 1400 && !cpu_pend && !cpu_drop && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1; cpu_we = 1'($urandom_range(0, 1));
        cpu_addr = ADDR_W'($urandom_range(0, 15)); cpu_wdata = DATA_W'($urandom);
        cpu_pend = 1'b1; cpu_wait = 0; cpu_reqs++;
      end
      if (cyc < 1400 && !vga_pend && !vga_drop && $urandom_range(0, 3) != 0) begin
        vga_req = 1'b1; vga_addr = ADDR_W'($urandom_range(0, 15));
        vga_pend = 1'b1; vga_reqs++;
      end
    end
    total_cnt++;
    if (cpu_pend || vga_pend || cpu_acks != cpu_reqs || vga_acks != vga_reqs)
      $display("FAIL rand_totals: cpu %0d/%0d vga %0d/%0d acks/reqs want equal, none pending",
               cpu_acks, cpu_reqs, vga_acks, vga_reqs);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; mem_load = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_req = 1'b0; vga_addr = '0;
    tick();
    mem_load = 1'b0;
    tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_cpu_write_read();
    test_vga_read();
    test_back_to_back();
    test_starvation();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
